// File: rtl/decode_pkg.sv
// Shared types for the decoder pipeline: decoded micro-op payload, RV64I major
// opcodes and exception codes.
package decode_pkg;

    localparam int unsigned UOP_XLEN = 64;

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM  = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    typedef enum logic [1:0] {
        EXC_NONE       = 2'd0,
        EXC_ILLEGAL    = 2'd1,
        EXC_MISALIGNED = 2'd2,
        EXC_ZERO       = 2'd3
    } exc_t;

    // imm and pc are carried at the widest supported XLEN, sign/zero extended
    typedef struct packed {
        logic                valid;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [UOP_XLEN-1:0] imm;
        logic [2:0]          func3;
        logic [6:0]          func7;
        logic                has_rd;
        logic                is_branch;
        logic                is_load;
        logic                is_store;
        exc_t                exc;
        logic [UOP_XLEN-1:0] pc;
    } decoded_uop_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/decode_slot.sv
// Combinational RV64I decoder for one bundle slot; a masked-off slot yields an
// all-zero micro-op.
module decode_slot
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output decoded_uop_t    uop_c
);

    logic [6:0]          opcode;
    logic                legal;
    logic [UOP_XLEN-1:0] imm;

    assign opcode = instr_i[6:0];

    always_comb begin
        legal = 1'b1;
        imm   = '0;
        case (opcode)
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                imm = {{52{instr_i[31]}}, instr_i[31:20]};
            OPC_STORE:
                imm = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_BRANCH:
                imm = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
            OPC_JAL:
                imm = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {{32{instr_i[31]}}, instr_i[31:12], 12'h000};
            OPC_OP, OPC_OP_32, OPC_MISC_MEM:
                imm = '0;
            default: begin
                imm   = '0;
                legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        uop_c = '0;
        if (valid_i) begin
            uop_c.valid     = 1'b1;
            uop_c.rd        = instr_i[11:7];
            uop_c.rs1       = instr_i[19:15];
            uop_c.rs2       = instr_i[24:20];
            uop_c.func3     = instr_i[14:12];
            uop_c.func7     = instr_i[31:25];
            uop_c.imm       = imm;
            uop_c.pc        = UOP_XLEN'(pc_i);
            uop_c.has_rd    = (opcode != OPC_BRANCH) && (opcode != OPC_STORE) &&
                              (instr_i[11:7] != 5'd0);
            uop_c.is_branch = (opcode == OPC_BRANCH) || (opcode == OPC_JAL) ||
                              (opcode == OPC_JALR);
            uop_c.is_load   = (opcode == OPC_LOAD);
            uop_c.is_store  = (opcode == OPC_STORE);
            // zero word outranks misaligned pc, which outranks illegal opcode
            if (instr_i == 32'h0) begin
                uop_c.exc = EXC_ZERO;
            end else if (pc_i[1:0] != 2'b00) begin
                uop_c.exc = EXC_MISALIGNED;
            end else if (!legal) begin
                uop_c.exc = EXC_ILLEGAL;
            end else begin
                uop_c.exc = EXC_NONE;
            end
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Bundle decoder: WIDTH slot decoders feeding a main register plus one skid
// register. Optional perf counters under DECODER_PIPE_PERF_EN.
module decoder_pipe
    import decode_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned XLEN  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [WIDTH-1:0]               in_mask_i,
    input  logic [WIDTH-1:0][31:0]         instr_i,
    input  logic [WIDTH-1:0][XLEN-1:0]     pc_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output decoded_uop_t [WIDTH-1:0]       out_uop_o
`ifdef DECODER_PIPE_PERF_EN
    ,
    output logic [31:0]                    perf_insn_o,
    output logic [31:0]                    perf_stall_o
`endif
);

    decoded_uop_t [WIDTH-1:0] dec_c;
    decoded_uop_t [WIDTH-1:0] main_q, main_d;
    decoded_uop_t [WIDTH-1:0] skid_q, skid_d;
    logic                     main_valid_q, main_valid_d;
    logic                     skid_valid_q, skid_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic                     in_take;
    logic                     out_fire;

    for (genvar g = 0; g < WIDTH; g++) begin : g_slot
        decode_slot #(.XLEN(XLEN)) u_slot (
            .valid_i (in_mask_i[g]),
            .instr_i (instr_i[g]),
            .pc_i    (pc_i[g]),
            .uop_c   (dec_c[g])
        );
    end

    // an all-masked bundle is accepted but never occupies a register
    assign in_take  = in_valid_i && in_ready_q && (|in_mask_i);
    assign out_fire = main_valid_q && out_ready_i;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready_i) begin
            // skid is only ever full while in_ready is low, so it never races in_take
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_take) begin
                main_d       = dec_c;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_take) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_uop_o   = main_q;

`ifdef DECODER_PIPE_PERF_EN
    logic [WIDTH-1:0] out_slot_vld;
    logic [31:0]      perf_insn_q, perf_insn_d;
    logic [31:0]      perf_stall_q, perf_stall_d;

    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            out_slot_vld[i] = main_q[i].valid;
        end
        perf_insn_d  = perf_insn_q;
        perf_stall_d = perf_stall_q;
        if (out_fire) begin
            perf_insn_d = perf_insn_q + 32'(popcount16(16'(out_slot_vld)));
        end
        if (main_valid_q && !out_ready_i) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_insn_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_insn_q  <= perf_insn_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_insn_o  = perf_insn_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed self-checking bench for decoder_pipe (WIDTH=8, XLEN=64); perf
// counter checks compile in with DECODER_PIPE_PERF_EN.
module tb_decoder_pipe;
    import decode_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [7:0]            mask = '0;
    logic [7:0][31:0]      instr = '0;
    logic [7:0][63:0]      pc = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    decoded_uop_t [7:0]    uop;
`ifdef DECODER_PIPE_PERF_EN
    logic [31:0]           perf_insn;
    logic [31:0]           perf_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    decoder_pipe #(.WIDTH(8), .XLEN(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_mask_i   (mask),
        .instr_i     (instr),
        .pc_i        (pc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_uop_o   (uop)
`ifdef DECODER_PIPE_PERF_EN
        ,
        .perf_insn_o (perf_insn),
        .perf_stall_o(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_valid = 1'b0;
        mask     = '0;
        instr    = '0;
        pc       = '0;
    endtask

    task automatic send1(input logic [31:0] w, input logic [63:0] p);
        clr_in();
        in_valid = 1'b1;
        mask     = 8'h01;
        instr[0] = w;
        pc[0]    = p;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkzero(input string tag, input decoded_uop_t obs);
        decoded_uop_t z;
        z = '0;
        n_cmp++;
        assert (obs === z) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=0", tag, obs);
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        repeat (2) step();
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chkzero("rst_uop0", uop[0]);
        rst = 1'b0;
        step();

        // single addi x1,x0,5
        send1(32'h00500093, 64'h1000);
        step();
        clr_in();
        chk1("addi_valid", out_valid, 1'b1);
        chk1("addi_slot_valid", uop[0].valid, 1'b1);
        chk5("addi_rd", uop[0].rd, 5'd1);
        chk64("addi_imm", uop[0].imm, 64'd5);
        chk1("addi_has_rd", uop[0].has_rd, 1'b1);
        chk64("addi_exc", 64'(uop[0].exc), 64'd0);
        chk64("addi_pc", uop[0].pc, 64'h1000);
        chkzero("masked_slot1", uop[1]);
        step();
        chk1("addi_drained", out_valid, 1'b0);

        // immediates: beq x0,x0,-4 and lui x1,0x80000
        clr_in();
        in_valid = 1'b1;
        mask     = 8'h03;
        instr[0] = 32'hFE000EE3; pc[0] = 64'h2000;
        instr[1] = 32'h800000B7; pc[1] = 64'h2004;
        step();
        clr_in();
        chk64("b_imm", uop[0].imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk1("b_is_branch", uop[0].is_branch, 1'b1);
        chk1("b_has_rd", uop[0].has_rd, 1'b0);
        chk64("lui_imm", uop[1].imm, 64'hFFFF_FFFF_8000_0000);
        chk5("lui_rd", uop[1].rd, 5'd1);
        chk1("lui_has_rd", uop[1].has_rd, 1'b1);
        step();

        // exceptions plus load/store decode
        in_valid = 1'b1;
        mask     = 8'h3F;
        instr[0] = 32'h00000000; pc[0] = 64'h3000;
        instr[1] = 32'h0000007F; pc[1] = 64'h3004;
        instr[2] = 32'h00500093; pc[2] = 64'h1002;
        instr[3] = 32'h00000000; pc[3] = 64'h3006;
        instr[4] = 32'h0080A103; pc[4] = 64'h3010;
        instr[5] = 32'h0020A623; pc[5] = 64'h3014;
        step();
        clr_in();
        chk64("exc_zero", 64'(uop[0].exc), 64'd3);
        chk64("exc_illegal", 64'(uop[1].exc), 64'd1);
        chk64("exc_misaligned", 64'(uop[2].exc), 64'd2);
        chk64("exc_zero_over_misaligned", 64'(uop[3].exc), 64'd3);
        chk1("lw_is_load", uop[4].is_load, 1'b1);
        chk64("lw_imm", uop[4].imm, 64'd8);
        chk5("lw_rd", uop[4].rd, 5'd2);
        chk5("lw_rs1", uop[4].rs1, 5'd1);
        chk1("sw_is_store", uop[5].is_store, 1'b1);
        chk64("sw_imm", uop[5].imm, 64'd12);
        chk5("sw_rs2", uop[5].rs2, 5'd2);
        chk1("sw_has_rd", uop[5].has_rd, 1'b0);
        chkzero("masked_slot6", uop[6]);
        step();

        // backpressure: A then B while out_ready low for 3 edges
        out_ready = 1'b0;
        send1(32'h00100093, 64'h4000);
        step();
        chk1("bp_a_valid", out_valid, 1'b1);
        chk1("bp_a_ready", in_ready, 1'b1);
        send1(32'h00200113, 64'h4004);
        step();
        clr_in();
        chk1("bp_skid_ready", in_ready, 1'b0);
        chk5("bp_hold_a1", uop[0].rd, 5'd1);
        step();
        chk5("bp_hold_a2", uop[0].rd, 5'd1);
        chk1("bp_skid_ready2", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        chk1("bp_b_valid", out_valid, 1'b1);
        chk5("bp_b_rd", uop[0].rd, 5'd2);
        chk1("bp_b_ready", in_ready, 1'b1);
        step();
        chk1("bp_empty", out_valid, 1'b0);

        // flush with both registers full and input pending
        out_ready = 1'b0;
        send1(32'h00300193, 64'h5000);
        step();
        send1(32'h00400213, 64'h5004);
        step();
        chk1("fl_full_ready", in_ready, 1'b0);
        send1(32'h00500293, 64'h5008);
        flush = 1'b1;
        step();
        chk1("fl_out_valid", out_valid, 1'b0);
        chk1("fl_in_ready", in_ready, 1'b1);
        send1(32'h00600313, 64'h500C);
        step();
        chk1("fl_accept_discard", out_valid, 1'b0);
        flush = 1'b0;
        clr_in();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("fl_no_stale", out_valid, 1'b0);
        end

        // all-zero mask is accepted but produces nothing
        clr_in();
        in_valid = 1'b1;
        instr[0] = 32'h00500093;
        step();
        clr_in();
        chk1("empty_mask_ready", in_ready, 1'b1);
        chk1("empty_mask_none", out_valid, 1'b0);

        // asynchronous reset with both registers full
        out_ready = 1'b0;
        send1(32'h00600313, 64'h6000);
        step();
        send1(32'h00700393, 64'h6004);
        step();
        clr_in();
        #2 rst = 1'b1;
        #1;
        chk1("arst_out_valid", out_valid, 1'b0);
        chk1("arst_in_ready", in_ready, 1'b1);
        chkzero("arst_uop0", uop[0]);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        send1(32'h00100093, 64'h7000);
        step();
        clr_in();
        chk1("post_rst_valid", out_valid, 1'b1);
        chk5("post_rst_rd", uop[0].rd, 5'd1);
        step();
        chk1("post_rst_no_stale", out_valid, 1'b0);

`ifdef DECODER_PIPE_PERF_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk64("perf_rst_insn", 64'(perf_insn), 64'd0);
        out_ready = 1'b0;
        clr_in();
        in_valid = 1'b1;
        mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            instr[i] = 32'h00100093;
            pc[i]    = 64'(32'h8000 + 4 * i);
        end
        step();
        in_valid = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        step();
        chk64("perf_insn", 64'(perf_insn), 64'd32);
        chk64("perf_stall", 64'(perf_stall), 64'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk64("perf_flush_keep", 64'(perf_insn), 64'd32);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
